// File: rtl/source_sink_pkg.sv
// source_sink_pkg: shared types and constants for the source/sink byte-stream link
package source_sink_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int CNT_W = 8;
    localparam int COUNT_W = 16;
    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;
    typedef enum logic [0:0] {SINK_WAIT, SINK_READY} sink_state_e;
endpackage

// File: rtl/sink_seq_checker.sv
// sink_seq_checker: compares accepted bytes against an incrementing sequence and keeps statistics
module sink_seq_checker
    import source_sink_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               xfer_i,
    input  logic               clr_i,
    input  logic [DATA_W-1:0]  data_i,
    output logic [DATA_W-1:0]  last_data_o,
    output logic [COUNT_W-1:0] count_o,
    output logic [7:0]         err_cnt_o,
    output logic               err_o
);
    logic [DATA_W-1:0]  exp_q, exp_d, last_q, last_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               err_q, err_d, mismatch;

    assign mismatch = xfer_i && (data_i != exp_q);

    // Clear wins for statistics; the expected value always resyncs to the accepted byte + 1
    always_comb begin
        last_d    = xfer_i ? data_i : last_q;
        exp_d     = xfer_i ? data_i + 1'b1 : (clr_i ? '0 : exp_q);
        count_d   = clr_i ? '0 : (xfer_i ? count_q + 1'b1 : count_q);
        err_cnt_d = clr_i ? '0 : ((mismatch && err_cnt_q != ERR_CNT_MAX) ? err_cnt_q + 1'b1 : err_cnt_q);
        err_d     = !clr_i && (err_q || mismatch);
    end

    // Statistics registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exp_q     <= '0;
            last_q    <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            exp_q     <= exp_d;
            last_q    <= last_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
        end
    end

    assign last_data_o = last_q;
    assign count_o     = count_q;
    assign err_cnt_o   = err_cnt_q;
    assign err_o       = err_q;
endmodule

// File: rtl/sink_checker.sv
// sink_checker: stream sink with programmable backpressure and sequence checking (optional stall timeout via SINK_TIMEOUT_EN)
module sink_checker
    import source_sink_pkg::*;
#(
    parameter int ATRASO = 4,
    parameter int DATA_W = DEF_DATA_W
`ifdef SINK_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic               clr_i,
    output logic               ready_o,
    output logic [DATA_W-1:0]  last_data_o,
    output logic [COUNT_W-1:0] count_o,
    output logic [7:0]         err_cnt_o,
    output logic               err_o
`ifdef SINK_TIMEOUT_EN
    ,
    output logic               timeout_o
`endif
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ATRASO - 1);

    sink_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d, xfer;

    assign xfer = valid_i && ready_q;

    // Backpressure FSM: hold ready low for ATRASO cycles, then wait for a transfer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        if (state_q == SINK_WAIT) begin
            if (ATRASO == 0 || cnt_q == LAST_CNT) begin
                cnt_d   = '0;
                ready_d = 1'b1;
                state_d = SINK_READY;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (xfer && ATRASO != 0) begin
            cnt_d   = '0;
            ready_d = 1'b0;
            state_d = SINK_WAIT;
        end
    end

    // FSM state, backpressure counter and registered ready
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SINK_WAIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o = ready_q;

    sink_seq_checker #(.DATA_W(DATA_W)) u_seq (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .xfer_i      (xfer),
        .clr_i       (clr_i),
        .data_i      (data_i),
        .last_data_o (last_data_o),
        .count_o     (count_o),
        .err_cnt_o   (err_cnt_o),
        .err_o       (err_o)
    );

`ifdef SINK_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    logic [15:0] stall_q, stall_d;
    logic        to_q, to_d;

    // Stall counter runs while ready and idle, holds at the limit; timeout flag is sticky
    always_comb begin
        stall_d = (clr_i || valid_i) ? '0 : ((ready_q && stall_q != TO_LIMIT) ? stall_q + 1'b1 : stall_q);
        to_d    = !clr_i && (to_q || stall_d == TO_LIMIT);
    end

    // Stall counter and timeout registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            to_q    <= 1'b0;
        end else begin
            stall_q <= stall_d;
            to_q    <= to_d;
        end
    end

    assign timeout_o = to_q;
`endif
endmodule

// File: doc/sink_checker.md
Name: sink_checker

Overview:
- Receiving end of the valid/ready byte stream produced by the source block.
- Accepts one byte per handshake. After each accepted byte, it applies programmable backpressure by holding `ready_o` low for ATRASO cycles.
- Checks every accepted byte against an expected incrementing sequence and keeps transfer and error statistics.
- Sits at the end of the source/sink link as the stream terminator and self-checking monitor.

Parameters:
- ATRASO, 4: cycles `ready_o` stays low after each accepted byte and after reset; 0 means `ready_o` is permanently high.
- DATA_W, 8: width of the data bus.
- TIMEOUT, 64: stall limit in cycles; used only when SINK_TIMEOUT_EN is defined.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous reset, active-high.
- valid_i  input  1  source has data on `data_i`.
- data_i  input  DATA_W  byte from the source.
- clr_i  input  1  synchronous clear of statistics and expected value.
- ready_o  output  1  sink can accept a byte this cycle (registered).
- last_data_o  output  DATA_W  last accepted byte.
- count_o  output  16  accepted-byte counter; wraps at 16'hFFFF -> 0.
- err_cnt_o  output  8  mismatch counter; saturates at 8'hFF.
- err_o  output  1  sticky: at least one mismatch since reset or clear.
- timeout_o  output  1  sticky stall flag; only exists with SINK_TIMEOUT_EN.

Behaviour:
- Reset (`rst_i` high at posedge), all registers go to:
  - state SINK_WAIT, cnt 0, exp 0;
  - `ready_o` 0, `last_data_o` 0, `count_o` 0, `err_cnt_o` 0, `err_o` 0, `timeout_o` 0.
  - Reset has priority over every other input. Reset mid-transfer discards the byte; nothing is counted.
- Handshake: a transfer occurs at a posedge where `valid_i` and `ready_o` are both 1. `valid_i` without `ready_o` is ignored. Data is sampled only at a transfer edge.
- FSM states: SINK_WAIT and SINK_READY.
  - SINK_WAIT:
    - cnt increments each cycle.
    - When cnt+1 == ATRASO: cnt is set to 0, `ready_o` is set to 1, and the FSM moves to SINK_READY.
  - SINK_READY:
    - `ready_o` holds 1 until a transfer.
    - On a transfer: `ready_o` is set to 0, cnt is set to 0, and the FSM moves to SINK_WAIT.
  - Net effect:
    - `ready_o` is low for exactly ATRASO cycles after reset release and after each transfer.
    - For ATRASO=4, a back-to-back stream gives 1 transfer per 5 cycles.
  - ATRASO == 0:
    - The FSM never leaves SINK_READY.
    - `ready_o` = 1 from the first edge after reset release, giving 1 transfer per cycle.
- Checker, on each transfer:
  - `last_data_o` is set to `data_i`.
  - `count_o` increments.
  - If `data_i` != exp: `err_cnt_o` increments (saturating) and `err_o` is set to 1.
  - exp is set to `data_i`+1 in both cases (mismatch and match), so the checker resynchronises on a mismatch.
  - exp wraps 8'hFF -> 0, and that wrap is not an error.
- `clr_i`:
  - Zeroes `count_o`, `err_cnt_o`, `err_o`, exp and `timeout_o`.
  - Does not change the FSM, cnt or `ready_o`.
  - If `clr_i` and a transfer occur in the same cycle, the clear wins for the statistics. `last_data_o` is still updated and exp is set to `data_i`+1.
- Latency: statistics are visible the cycle after the transfer edge.

Optional Feature:
- SINK_TIMEOUT_EN defined:
  - A 16-bit stall counter counts cycles where `ready_o`=1 and `valid_i`=0.
  - It resets to 0 on any cycle with `valid_i`=1, on `clr_i`, and on reset.
  - When the counter reaches TIMEOUT, `timeout_o` is set to 1 (sticky until `clr_i` or `rst_i`) and the counter holds.
- SINK_TIMEOUT_EN undefined: the `timeout_o` port, the stall counter and the TIMEOUT logic are absent.

Decomposition:
- Package source_sink_pkg holds:
  - DATA_W default and CNT_W=8;
  - typedef enum logic [0:0] sink_state_e {SINK_WAIT, SINK_READY};
  - constants ERR_CNT_MAX=8'hFF and COUNT_W=16.
- Sub-module sink_seq_checker holds the expected/compare/statistics logic and receives the transfer strobe and data.
- sink_checker keeps the FSM, backpressure counter and timeout logic.

Test Plan:
- ATRASO=4, `valid_i` held 1 with `data_i`=0,1,2…: `ready_o` low 4 cycles after reset release, one transfer every 5 cycles. After 10 bytes: `count_o`=10, `err_o`=0, `last_data_o`=9.
- ATRASO=0, continuous stream of 0..255 then 0..3: a transfer every cycle, `count_o`=260, no error across the FF->00 wrap.
- Stream 0,1,2,7,8: `err_cnt_o`=1, `err_o`=1, `count_o`=5 (no error at 8, because of resync).
- Assert `rst_i` while `valid_i`=1 and `ready_o`=1: all outputs are 0 next cycle, no transfer counted. `ready_o` returns 4 cycles after release.
- 300 forced mismatches: `err_cnt_o` saturates at 255. Then pulse `clr_i` in the same cycle as a transfer of 5: `err_cnt_o`=0, `count_o`=0, `last_data_o`=5, next expected byte is 6.
- With SINK_TIMEOUT_EN and TIMEOUT=64: `valid_i`=0 for 64 cycles while `ready_o`=1 sets `timeout_o`. 63 idle cycles followed by valid does not set it.
